// File: rtl/msrv32_redirect_ctrl.sv
// Purpose : owns the fetch PC and sequences redirects (branch/JAL/JALR, trap, mret) with a flush window.
// Latency : all outputs registered; a redirect sampled at edge N shows on pc_out/flush_out from cycle N+1.
// Backpress: stall_in freezes PC, state and flush counter; trap_taken_in/mret_in act even while stalled.
//
// Optional feature macro: MSRV32_REDIRECT_STATS_EN (adds redirect_count_out).
//
// Ports:
//   ms_riscv32_mp_clk_in / ms_riscv32_mp_rst_n_in : core clock, async active-low reset
//   branch_taken_in, target_addr_in                : branch unit redirect request and target
//   stall_in                                       : hold PC/state (does not block trap/mret)
//   trap_taken_in, trap_addr_in                    : trap entry and vector
//   mret_in, epc_in                                : trap return and mepc
//   pc_out                                         : registered fetch PC
//   flush_out                                      : squash in-flight instructions
//   misaligned_exception_out, misaligned_addr_out  : misaligned-target pulse and captured address
//   redirect_count_out (macro only)                : saturating count of accepted redirects

module msrv32_redirect_ctrl #(
  parameter logic [31:0] BOOT_ADDR    = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_n_in,
  input  logic        branch_taken_in,
  input  logic [31:0] target_addr_in,
  input  logic        stall_in,
  input  logic        trap_taken_in,
  input  logic [31:0] trap_addr_in,
  input  logic        mret_in,
  input  logic [31:0] epc_in,
  output logic [31:0] pc_out,
  output logic        flush_out,
  output logic        misaligned_exception_out,
  output logic [31:0] misaligned_addr_out
`ifdef MSRV32_REDIRECT_STATS_EN
  ,
  output logic [31:0] redirect_count_out
`endif
);

  typedef enum logic [1:0] {
    ST_BOOT      = 2'd0,
    ST_RUN       = 2'd1,
    ST_FLUSH     = 2'd2,
    ST_TRAP_WAIT = 2'd3
  } state_t;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  state_t      state;
  logic [2:0]  flush_cnt;
  logic [31:0] eff_target;
  logic        target_misaligned;
  logic        branch_accept;

  // JALR semantics: bit0 is discarded; bit1 set means not 4-byte aligned.
  assign eff_target        = {target_addr_in[31:1], 1'b0};
  assign target_misaligned = eff_target[1];

  // Branch requests are only honoured in RUN while not stalled; otherwise upstream holds them.
  assign branch_accept = (state == ST_RUN) && !stall_in && branch_taken_in;

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      state                    <= ST_BOOT;
      pc_out                   <= BOOT_ADDR;
      flush_cnt                <= 3'd0;
      flush_out                <= 1'b1;
      misaligned_exception_out <= 1'b0;
      misaligned_addr_out      <= 32'd0;
    end else begin
      // Exception is a single-cycle pulse unless re-raised below.
      misaligned_exception_out <= 1'b0;

      if (trap_taken_in) begin
        // Trap wins over a simultaneous mret and clears the stale mtval capture.
        pc_out              <= trap_addr_in & ~32'd3;
        flush_cnt           <= FLUSH_LOAD;
        state               <= ST_FLUSH;
        flush_out           <= 1'b1;
        misaligned_addr_out <= 32'd0;
      end else if (mret_in) begin
        pc_out    <= epc_in & ~32'd3;
        flush_cnt <= FLUSH_LOAD;
        state     <= ST_FLUSH;
        flush_out <= 1'b1;
      end else begin
        case (state)
          ST_BOOT: begin
            // One-cycle boot window; PC stays at BOOT_ADDR into the first RUN cycle.
            state     <= ST_RUN;
            flush_out <= 1'b0;
          end

          ST_RUN: begin
            if (branch_accept) begin
              if (target_misaligned) begin
                // PC is held; flush stays up until the resulting trap's flush completes.
                misaligned_exception_out <= 1'b1;
                misaligned_addr_out      <= eff_target;
                state                    <= ST_TRAP_WAIT;
                flush_out                <= 1'b1;
              end else begin
                // A redirect to the current PC still takes the flush path.
                pc_out    <= eff_target;
                flush_cnt <= FLUSH_LOAD;
                state     <= ST_FLUSH;
                flush_out <= 1'b1;
              end
            end else if (!stall_in) begin
              pc_out <= pc_out + 32'd4;
            end
          end

          ST_FLUSH: begin
            if (!stall_in) begin
              pc_out    <= pc_out + 32'd4;
              flush_cnt <= flush_cnt - 3'd1;
              // <= 1 also recovers from an out-of-range zero load.
              if (flush_cnt <= 3'd1) begin
                state     <= ST_RUN;
                flush_out <= 1'b0;
                flush_cnt <= 3'd0;
              end
            end
          end

          ST_TRAP_WAIT: begin
            // Only trap_taken_in or mret_in (handled above) leave this state.
            flush_out <= 1'b1;
          end

          default: begin
            state     <= ST_BOOT;
            flush_out <= 1'b1;
          end
        endcase
      end
    end
  end

`ifdef MSRV32_REDIRECT_STATS_EN
  logic redirect_accept;

  // Counts trap, mret and both branch outcomes (aligned redirect and misaligned exception).
  assign redirect_accept = trap_taken_in || mret_in || branch_accept;

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      redirect_count_out <= 32'd0;
    end else if (redirect_accept && (redirect_count_out != 32'hFFFF_FFFF)) begin
      redirect_count_out <= redirect_count_out + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_msrv32_redirect_ctrl.sv
// Purpose : directed checks of msrv32_redirect_ctrl (BOOT_ADDR=0x1000, FLUSH_CYCLES=2).
// Latency : expectations are sampled 1 time unit after each rising edge.
// Backpress: exercises stall_in both in RUN (branch held) and in FLUSH (counter frozen).

module tb_msrv32_redirect_ctrl;

  logic        clk;
  logic        rst_n;
  logic        branch_taken;
  logic [31:0] target_addr;
  logic        stall;
  logic        trap_taken;
  logic [31:0] trap_addr;
  logic        mret;
  logic [31:0] epc;
  logic [31:0] pc;
  logic        flush;
  logic        mis_exc;
  logic [31:0] mis_addr;
`ifdef MSRV32_REDIRECT_STATS_EN
  logic [31:0] redirect_count;
`endif

  int n_compared   = 0;
  int n_mismatched = 0;

  msrv32_redirect_ctrl #(
    .BOOT_ADDR    (32'h0000_1000),
    .FLUSH_CYCLES (2)
  ) dut (
    .ms_riscv32_mp_clk_in     (clk),
    .ms_riscv32_mp_rst_n_in   (rst_n),
    .branch_taken_in          (branch_taken),
    .target_addr_in           (target_addr),
    .stall_in                 (stall),
    .trap_taken_in            (trap_taken),
    .trap_addr_in             (trap_addr),
    .mret_in                  (mret),
    .epc_in                   (epc),
    .pc_out                   (pc),
    .flush_out                (flush),
    .misaligned_exception_out (mis_exc),
    .misaligned_addr_out      (mis_addr)
`ifdef MSRV32_REDIRECT_STATS_EN
    ,
    .redirect_count_out       (redirect_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks pc_out and flush_out together.
  task automatic expect_pf(input string tag, input logic [31:0] exp_pc, input logic exp_flush);
    check_val({tag, ".pc"}, pc, exp_pc);
    check_val({tag, ".flush"}, {31'd0, flush}, {31'd0, exp_flush});
  endtask

  initial begin
    rst_n        = 1'b0;
    branch_taken = 1'b0;
    target_addr  = 32'd0;
    stall        = 1'b0;
    trap_taken   = 1'b0;
    trap_addr    = 32'd0;
    mret         = 1'b0;
    epc          = 32'd0;

    // Reset values
    tick();
    tick();
    expect_pf("rst", 32'h0000_1000, 1'b1);
    check_val("rst.exc", {31'd0, mis_exc}, 32'd0);
    check_val("rst.maddr", mis_addr, 32'd0);
    rst_n = 1'b1;

    // BOOT cycle, then first RUN cycle keeps BOOT_ADDR, then sequential
    expect_pf("boot", 32'h0000_1000, 1'b1);
    tick(); expect_pf("run0", 32'h0000_1000, 1'b0);
    tick(); expect_pf("run1", 32'h0000_1004, 1'b0);
    tick(); expect_pf("run2", 32'h0000_1008, 1'b0);

    // Branch to 0x1FF8; flush window advances PC to 0x2000
    branch_taken = 1'b1; target_addr = 32'h0000_1FF8;
    tick(); expect_pf("br1ff8.a", 32'h0000_1FF8, 1'b1);
    branch_taken = 1'b0;
    tick(); expect_pf("br1ff8.b", 32'h0000_1FFC, 1'b1);
    tick(); expect_pf("br1ff8.c", 32'h0000_2000, 1'b0);

    // Branch 0x2000 -> 0x3000, flush exactly 2 cycles
    branch_taken = 1'b1; target_addr = 32'h0000_3000;
    tick(); expect_pf("br3000.a", 32'h0000_3000, 1'b1);
    branch_taken = 1'b0;
    tick(); expect_pf("br3000.b", 32'h0000_3004, 1'b1);
    tick(); expect_pf("br3000.c", 32'h0000_3008, 1'b0);

    // JALR 0x4001 lands on 0x4000 without exception
    branch_taken = 1'b1; target_addr = 32'h0000_4001;
    tick(); expect_pf("jalr.a", 32'h0000_4000, 1'b1);
    check_val("jalr.exc", {31'd0, mis_exc}, 32'd0);
    branch_taken = 1'b0;
    tick(); expect_pf("jalr.b", 32'h0000_4004, 1'b1);
    tick(); expect_pf("jalr.c", 32'h0000_4008, 1'b0);

    // Stall inside FLUSH freezes PC and the flush counter
    branch_taken = 1'b1; target_addr = 32'h0000_4100;
    tick(); expect_pf("fstall.a", 32'h0000_4100, 1'b1);
    branch_taken = 1'b0; stall = 1'b1;
    tick(); expect_pf("fstall.b", 32'h0000_4100, 1'b1);
    tick(); expect_pf("fstall.c", 32'h0000_4100, 1'b1);
    stall = 1'b0;
    tick(); expect_pf("fstall.d", 32'h0000_4104, 1'b1);
    tick(); expect_pf("fstall.e", 32'h0000_4108, 1'b0);

    // Stall in RUN with branch held for 3 cycles: nothing moves
    stall = 1'b1; branch_taken = 1'b1; target_addr = 32'h0000_6000;
    for (int i = 0; i < 3; i++) begin
      tick(); expect_pf("rstall", 32'h0000_4108, 1'b0);
    end
    stall = 1'b0;
    tick(); expect_pf("rstall.go", 32'h0000_6000, 1'b1);
    branch_taken = 1'b0;
    tick(); expect_pf("rstall.b", 32'h0000_6004, 1'b1);
    tick(); expect_pf("rstall.c", 32'h0000_6008, 1'b0);

    // Misaligned target 0x5002: one-cycle pulse, PC held, address captured
    branch_taken = 1'b1; target_addr = 32'h0000_5002;
    tick(); expect_pf("mis.a", 32'h0000_6008, 1'b1);
    check_val("mis.a.exc", {31'd0, mis_exc}, 32'd1);
    check_val("mis.a.maddr", mis_addr, 32'h0000_5002);
    target_addr = 32'h0000_7000;  // branch still high: ignored in TRAP_WAIT
    tick(); expect_pf("mis.b", 32'h0000_6008, 1'b1);
    check_val("mis.b.exc", {31'd0, mis_exc}, 32'd0);
    check_val("mis.b.maddr", mis_addr, 32'h0000_5002);
    branch_taken = 1'b0; trap_taken = 1'b1; trap_addr = 32'h0000_0103;
    tick(); expect_pf("trap.a", 32'h0000_0100, 1'b1);
    check_val("trap.maddr", mis_addr, 32'd0);
    trap_taken = 1'b0;
    tick(); expect_pf("trap.b", 32'h0000_0104, 1'b1);
    tick(); expect_pf("trap.c", 32'h0000_0108, 1'b0);

    // mret aligns epc
    mret = 1'b1; epc = 32'h0000_0207;
    tick(); expect_pf("mret.a", 32'h0000_0204, 1'b1);
    mret = 1'b0;
    tick(); expect_pf("mret.b", 32'h0000_0208, 1'b1);
    tick(); expect_pf("mret.c", 32'h0000_020C, 1'b0);

    // PC wrap 0xFFFF_FFFC -> 0
    mret = 1'b1; epc = 32'hFFFF_FFF4;
    tick(); expect_pf("wrap.a", 32'hFFFF_FFF4, 1'b1);
    mret = 1'b0;
    tick(); expect_pf("wrap.b", 32'hFFFF_FFF8, 1'b1);
    tick(); expect_pf("wrap.c", 32'hFFFF_FFFC, 1'b0);
    tick(); expect_pf("wrap.d", 32'h0000_0000, 1'b0);

    // Simultaneous trap and mret: trap wins
    trap_taken = 1'b1; trap_addr = 32'h0000_0300; mret = 1'b1; epc = 32'h0000_0400;
    tick(); expect_pf("both", 32'h0000_0300, 1'b1);
    trap_taken = 1'b0; mret = 1'b0;
    tick(); expect_pf("both.b", 32'h0000_0304, 1'b1);
    tick(); expect_pf("both.c", 32'h0000_0308, 1'b0);

    // Redirect to the current PC still flushes
    branch_taken = 1'b1; target_addr = 32'h0000_0308;
    tick(); expect_pf("self.a", 32'h0000_0308, 1'b1);
    branch_taken = 1'b0;
    tick(); expect_pf("self.b", 32'h0000_030C, 1'b1);
    tick(); expect_pf("self.c", 32'h0000_0310, 1'b0);

    // Reset during TRAP_WAIT discards the pending exception state
    branch_taken = 1'b1; target_addr = 32'h0000_7002;
    tick(); check_val("rtw.exc", {31'd0, mis_exc}, 32'd1);
    check_val("rtw.maddr", mis_addr, 32'h0000_7002);
    branch_taken = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    expect_pf("rtw.rst", 32'h0000_1000, 1'b1);
    check_val("rtw.rst.exc", {31'd0, mis_exc}, 32'd0);
    check_val("rtw.rst.maddr", mis_addr, 32'd0);
    #1 rst_n = 1'b1;
    tick(); expect_pf("rtw.run", 32'h0000_1000, 1'b0);
    tick(); expect_pf("rtw.run1", 32'h0000_1004, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
